// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the alignment rule applied to every incoming request.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    STORE_RD = 3'd2,
    STORE_WR = 3'd3,
    RESP     = 3'd4
  } lsu_state_e;

  // Returns 1 for any access the block refuses, so ILLEGAL size counts too.
  function automatic logic misaligned(lsu_size_e size, logic [1:0] addr_lo);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = addr_lo[0];
      WORD:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: extracts and extends load data, and merges
// sub-word store data into the old memory word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [WIDTH-1:0] i_new_data,
  input  logic [1:0]       i_addr_lo,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  output logic [WIDTH-1:0] o_load_data,
  output logic [WIDTH-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    o_load_data = i_word;
    case (lsu_size_e'(i_size))
      BYTE:    o_load_data = {{(WIDTH-8){~i_unsigned & w_byte[7]}}, w_byte};
      HALF:    o_load_data = {{(WIDTH-16){~i_unsigned & w_half[15]}}, w_half};
      default: o_load_data = i_word;
    endcase

    // A full-word "merge" simply replaces the word.
    o_merged = i_word;
    case (lsu_size_e'(i_size))
      BYTE: begin
        case (i_addr_lo)
          2'd1:    o_merged[15:8]  = i_new_data[7:0];
          2'd2:    o_merged[23:16] = i_new_data[7:0];
          2'd3:    o_merged[31:24] = i_new_data[7:0];
          default: o_merged[7:0]   = i_new_data[7:0];
        endcase
      end
      HALF: begin
        if (i_addr_lo[1]) o_merged[31:16] = i_new_data[15:0];
        else              o_merged[15:0]  = i_new_data[15:0];
      end
      default: o_merged = i_new_data;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store initiator: one access at a time, alignment checked, sub-word
// stores done as read-modify-write against a word-only data memory.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE and out of reset.
  // The response is a single rsp_valid pulse with no backpressure.

  lsu_state_e       r_state;
  lsu_state_e       w_next_state;
  logic             r_we;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_wdata_q;
  logic [WIDTH-1:0] r_rdata_q;
  logic             r_err;

  logic             w_accept;
  logic             w_req_err;
  logic [WIDTH-1:0] w_load_data;
  logic [WIDTH-1:0] w_merged;

  assign req_ready = (r_state == IDLE) && reset_n;
  assign w_accept  = req_valid && req_ready;
  assign w_req_err = misaligned(lsu_size_e'(req_size), req_addr[1:0]);

  lsu_lane_align #(
    .WIDTH(WIDTH)
  ) u_lane_align (
    .i_word      (mem_rdata),
    .i_new_data  (r_wdata),
    .i_addr_lo   (r_addr[1:0]),
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  always_comb begin
    w_next_state = r_state;
    mem_write    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_req_err)                           w_next_state = RESP;
          else if (!req_we)                        w_next_state = LOAD;
          else if (lsu_size_e'(req_size) == WORD)  w_next_state = STORE_WR;
          else                                     w_next_state = STORE_RD;
        end
      end
      LOAD:     w_next_state = RESP;
      STORE_RD: w_next_state = STORE_WR;
      STORE_WR: begin
        mem_write    = 1'b1;
        w_next_state = RESP;
      end
      RESP:     w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = rsp_valid & r_err;
  assign rsp_rdata = rsp_valid ? r_rdata_q : '0;
  assign mem_addr  = {r_addr[WIDTH-1:2], 2'b00};
  assign mem_wdata = r_wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wdata_q  <= '0;
      r_rdata_q  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_we       <= req_we;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        // Word stores skip the read phase, so their data goes straight in.
        r_wdata_q  <= req_wdata;
        r_rdata_q  <= '0;
        r_err      <= w_req_err;
      end
      if (r_state == LOAD)     r_rdata_q <= w_load_data;
      if (r_state == STORE_RD) r_wdata_q <= w_merged;
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Scoreboard bench for lsu_mem_if: a word memory model, a byte-array
// reference model, directed scenarios followed by randomized traffic.
module tb_lsu_mem_if;
  import lsu_pkg::*;

  localparam int W      = 32;
  localparam int DEPTH  = 64;
  localparam int NBYTES = DEPTH * 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [1:0]   req_size = 2'b00;
  logic         req_unsigned = 1'b0;
  logic [W-1:0] req_addr = '0;
  logic [W-1:0] req_wdata = '0;
  logic         rsp_valid;
  logic [W-1:0] rsp_rdata;
  logic         rsp_err;
  logic         mem_write;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_if #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Data memory: combinational read, clocked write, cleared by reset.
  logic [W-1:0] mem [DEPTH];
  assign mem_rdata = mem[mem_addr[7:2]];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  // Reference model: plain byte array, little-endian.
  logic [7:0] ref_mem [NBYTES];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int acc_cnt = 0;
  int issued = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  int           exp_lat_q[$];
  int           exp_wr_q[$];
  int           acc_cyc_q[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic int nbytes_of(input int sz);
    return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
  endfunction

  function automatic logic ref_err(input int sz, input int addr);
    return (sz == 3) || (sz == 1 && (addr % 2) != 0) || (sz == 2 && (addr % 4) != 0);
  endfunction

  function automatic logic [W-1:0] ref_load(input int sz, input logic uns, input int addr);
    int     n;
    longint v;
    n = nbytes_of(sz);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[addr + i]) << (8 * i));
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[W-1:0];
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic we, input int sz, input logic uns, input int addr,
                       input logic [W-1:0] wdata, input logic hold);
    int   waited;
    logic err;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz[1:0];
    req_unsigned = uns;
    req_addr     = W'(addr);
    req_wdata    = wdata;
    waited = 0;
    while (!req_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 20) begin
        fail_now("req_ready_timeout");
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    issued++;
    err = ref_err(sz, addr);
    acc_cyc_q.push_back(cyc);
    exp_err_q.push_back(err);
    if (err)                 exp_lat_q.push_back(1);
    else if (!we || sz == 2) exp_lat_q.push_back(2);
    else                     exp_lat_q.push_back(3);
    exp_wr_q.push_back((we && !err) ? 1 : 0);
    if (err || we) exp_q.push_back('0);
    else           exp_q.push_back(ref_load(sz, uns, addr));
    if (we && !err) begin
      for (int i = 0; i < nbytes_of(sz); i++) ref_mem[addr + i] = wdata[8*i +: 8];
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      waited++;
      if (waited > 50) begin
        fail_now("drain_timeout");
        exp_q.delete(); exp_err_q.delete(); exp_lat_q.delete();
        exp_wr_q.delete(); acc_cyc_q.delete();
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every response, away from the active edge.
  always @(negedge clk) begin
    if (mem_write) begin
      wr_cnt++;
      check("mem_addr_word_aligned", {mem_addr[W-1:8], 6'b0, mem_addr[1:0]}, '0);
    end
    if (req_valid && req_ready) acc_cnt++;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_rsp_valid");
      end else begin
        check("rsp_rdata", rsp_rdata, exp_q.pop_front());
        check("rsp_err", W'(rsp_err), W'(exp_err_q.pop_front()));
        check("latency", W'(cyc + 1 - acc_cyc_q.pop_front()), W'(exp_lat_q.pop_front()));
        check("mem_write_cycles", W'(wr_cnt), W'(exp_wr_q.pop_front()));
      end
      wr_cnt = 0;
    end
  end

  initial begin
    int waited;
    ref_clear();

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_req_ready", W'(req_ready), '0);
    check("reset_rsp_valid", W'(rsp_valid), '0);
    check("reset_mem_write", W'(mem_write), '0);
    check("reset_mem_addr", mem_addr, '0);
    check("reset_mem_wdata", mem_wdata, '0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_req_ready", W'(req_ready), 32'd1);

    // Word store then load.
    issue(1'b1, 2, 1'b0, 'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 2, 1'b0, 'h10, '0, 1'b0);
    drain();
    check("mem_word_0x10", mem[4], 32'hDEADBEEF);

    // Byte store read-modify-write.
    issue(1'b1, 2, 1'b0, 'h20, 32'h11223344, 1'b0);
    issue(1'b1, 0, 1'b0, 'h22, 32'hFFFFFFAB, 1'b0);
    drain();
    check("mem_word_0x20_rmw", mem[8], 32'h11AB3344);

    // Sign/zero extension.
    issue(1'b1, 2, 1'b0, 'h30, 32'h80FF7F01, 1'b0);
    issue(1'b0, 0, 1'b0, 'h31, '0, 1'b0);
    issue(1'b0, 0, 1'b0, 'h32, '0, 1'b0);
    issue(1'b0, 1, 1'b1, 'h32, '0, 1'b0);
    issue(1'b0, 1, 1'b0, 'h32, '0, 1'b0);
    drain();

    // Errors: misaligned word load, misaligned half store, illegal size.
    issue(1'b0, 2, 1'b0, 'h06, '0, 1'b0);
    issue(1'b1, 1, 1'b0, 'h09, 32'h0000CAFE, 1'b0);
    issue(1'b0, 3, 1'b0, 'h10, '0, 1'b0);
    issue(1'b1, 3, 1'b0, 'h10, 32'h12345678, 1'b0);
    drain();
    check("mem_word_0x08_untouched", mem[2], '0);

    // Back-to-back: request held valid across five loads.
    for (int i = 0; i < 5; i++) issue(1'b0, i % 3, i[0], 'h30 + (i % 3 == 2 ? 0 : i % 3 == 1 ? 2 : i), '0, i != 4);
    drain();

    // Reset abort during the write cycle of a half store.
    issue(1'b1, 1, 1'b0, 'h42, 32'h00005A5A, 1'b0);
    waited = 0;
    while (!mem_write && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("abort_reached_store_wr", W'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    exp_q.delete(); exp_err_q.delete(); exp_lat_q.delete();
    exp_wr_q.delete(); acc_cyc_q.delete();
    wr_cnt = 0;
    ref_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp_valid", W'(rsp_valid), '0);
      check("abort_no_mem_write", W'(mem_write), '0);
    end
    reset_n = 1'b1;
    #1;
    check("post_abort_req_ready", W'(req_ready), 32'd1);
    check("post_abort_outputs", {rsp_valid, rsp_err, mem_write, 29'd0} | rsp_rdata, '0);
    check("post_abort_mem_addr", mem_addr, '0);
    check("post_abort_mem_wdata", mem_wdata, '0);
    check("post_abort_mem_word", mem[16], '0);
    @(posedge clk);
    #1;

    // Randomized traffic against the byte-array model.
    for (int n = 0; n < 120; n++) begin
      int r, sz, addr;
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      addr = $urandom_range(0, NBYTES - 1);
      if ($urandom_range(0, 9) < 7 && sz != 3) addr = addr - (addr % nbytes_of(sz));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
            $urandom, 1'($urandom_range(0, 1)));
      if (req_valid == 1'b0) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    drain();
    for (int i = 0; i < DEPTH; i++)
      check("final_mem_word", mem[i],
            {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
    check("accept_count", W'(acc_cnt), W'(issued));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "global timeout");
  end

endmodule
